// File: rtl/simon_pkg.sv
// simon_pkg: colour codes, input_state FSM encodings and button decode helpers
// shared by the player-input path.
`default_nettype none

package simon_pkg;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] GREEN  = 2'b01;
    localparam logic [1:0] BLUE   = 2'b10;
    localparam logic [1:0] YELLOW = 2'b11;

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] ARMED        = 2'd1;
    localparam logic [1:0] WAIT_RELEASE = 2'd2;

    function automatic logic [1:0] btn_to_colour(input logic [3:0] btn);
        logic [1:0] col;
        col = RED;
        if (btn[3])      col = YELLOW;
        else if (btn[2]) col = BLUE;
        else if (btn[1]) col = GREEN;
        return col;
    endfunction

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic int cnt_width(input int p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser on a 4-bit button vector followed by a
// stable-sample counter; the debounced vector updates after DEBOUNCE_CYCLES equal samples.
`default_nettype none

module btn_debounce
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100_000
) (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_btn,
    output logic [3:0] o_btn_db
);

    localparam int              CW         = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   C_CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [3:0]    r_db;
    logic [CW-1:0] r_cnt;

    // r_sync1 is the newest sample, r_sync2 the previous one
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 4'd0;
            r_sync2 <= 4'd0;
            r_db    <= 4'd0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (r_sync1 != r_sync2) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_LAST) begin
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_btn_db = r_db;

endmodule

`default_nettype wire

// File: rtl/input_state.sv
// input_state: captures one round of player presses and checks them against the
// stored colour sequence. Optional inter-press timeout enabled by INPUT_TIMEOUT_EN.
`default_nettype none

module input_state
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100_000,
    parameter int TIMEOUT_CYCLES  = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_input_n,
    input  logic        en_input,
    input  logic [31:0] seq_in_input,
    input  logic [3:0]  round_ctr,
    input  logic [3:0]  btn_in,
    output logic [1:0]  colour_bus,
    output logic        colour_oe,
    output logic        complete_input,
    output logic        fail_input
);

    logic [3:0] w_db;
    logic       w_press;
    logic       w_onehot;
    logic [1:0] w_press_col;
    logic [1:0] w_exp_col;
    logic       w_timeout;

    logic [1:0] r_state;
    logic [3:0] r_pos;
    logic [3:0] r_db_prev;
    logic [1:0] r_colour;
    logic       r_oe;
    logic       r_complete;
    logic       r_fail;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .i_rst_n  (rst_input_n),
        .i_btn    (btn_in),
        .o_btn_db (w_db)
    );

    // A press is only the 0000 -> non-zero edge, so a button held on entry is ignored
    assign w_press     = (r_state == ARMED) && (r_db_prev == 4'd0) && (w_db != 4'd0);
    assign w_onehot    = is_onehot(w_db);
    assign w_press_col = btn_to_colour(w_db);
    assign w_exp_col   = seq_in_input[{r_pos, 1'b0} +: 2];

`ifdef INPUT_TIMEOUT_EN
    localparam int            TW          = cnt_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] C_TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_to_cnt;

    always_ff @(posedge clk) begin
        if (!rst_input_n) begin
            r_to_cnt <= '0;
        end else if ((r_state != ARMED) || w_press) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == ARMED) && (r_to_cnt == C_TO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_input_n) begin
            r_state    <= IDLE;
            r_pos      <= 4'd0;
            r_db_prev  <= 4'd0;
            r_colour   <= 2'b00;
            r_oe       <= 1'b0;
            r_complete <= 1'b0;
            r_fail     <= 1'b0;
        end else begin
            r_complete <= 1'b0;
            r_fail     <= 1'b0;
            r_db_prev  <= w_db;
            if (!en_input) begin
                r_state <= IDLE;
                r_oe    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_oe    <= 1'b0;
                        r_pos   <= 4'd0;
                        r_state <= ARMED;
                    end
                    ARMED: begin
                        r_oe <= 1'b0;
                        if (w_press) begin
                            if (!w_onehot) begin
                                r_fail  <= 1'b1;
                                r_state <= IDLE;
                            end else begin
                                r_colour <= w_press_col;
                                r_oe     <= 1'b1;
                                if (w_press_col == w_exp_col) begin
                                    r_state <= WAIT_RELEASE;
                                end else begin
                                    r_fail  <= 1'b1;
                                    r_state <= IDLE;
                                end
                            end
                        end else if (w_timeout) begin
                            r_fail  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                    WAIT_RELEASE: begin
                        if (w_db == 4'd0) begin
                            r_oe <= 1'b0;
                            if (r_pos == round_ctr) begin
                                r_complete <= 1'b1;
                                r_state    <= IDLE;
                            end else begin
                                r_pos   <= r_pos + 4'd1;
                                r_state <= ARMED;
                            end
                        end
                    end
                    default: begin
                        r_oe    <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign colour_bus     = r_colour;
    assign colour_oe      = r_oe;
    assign complete_input = r_complete;
    assign fail_input     = r_fail;

endmodule

`default_nettype wire

// File: tb/tb_input_state.sv
// tb_input_state: self-checking bench for input_state with DEBOUNCE_CYCLES=4,
// TIMEOUT_CYCLES=64; honours INPUT_TIMEOUT_EN when defined.
`default_nettype none

module tb_input_state;

    logic        clk = 1'b0;
    logic        rst_input_n;
    logic        en_input;
    logic [31:0] seq_in_input;
    logic [3:0]  round_ctr;
    logic [3:0]  btn_in;
    logic [1:0]  colour_bus;
    logic        colour_oe;
    logic        complete_input;
    logic        fail_input;

    int total = 0;
    int bad   = 0;

    int n_comp = 0;
    int n_fail = 0;
    int n_overlap = 0;
    int n_wide = 0;
    logic prev_comp = 1'b0;
    logic prev_fail = 1'b0;

    always #5 clk = ~clk;

    input_state #(
        .DEBOUNCE_CYCLES (4),
        .TIMEOUT_CYCLES  (64)
    ) dut (
        .clk            (clk),
        .rst_input_n    (rst_input_n),
        .en_input       (en_input),
        .seq_in_input   (seq_in_input),
        .round_ctr      (round_ctr),
        .btn_in         (btn_in),
        .colour_bus     (colour_bus),
        .colour_oe      (colour_oe),
        .complete_input (complete_input),
        .fail_input     (fail_input)
    );

    // Pulse bookkeeping: counts pulses and flags overlap or pulses longer than one cycle
    always @(negedge clk) begin
        if (complete_input) n_comp <= n_comp + 1;
        if (fail_input)     n_fail <= n_fail + 1;
        if (complete_input && fail_input) n_overlap <= n_overlap + 1;
        if ((complete_input && prev_comp) || (fail_input && prev_fail)) n_wide <= n_wide + 1;
        prev_comp <= complete_input;
        prev_fail <= fail_input;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holds vector v for 'hold' cycles; if chk, expects colour col on the bus mid-hold
    task automatic press_hold(input logic [3:0] v, input int hold, input logic chk, input logic [1:0] col);
        btn_in = v;
        for (int k = 1; k <= hold; k++) begin
            @(negedge clk);
            if (chk && k == 8) begin
                total++;
                if (colour_oe !== 1'b1 || colour_bus !== col) begin
                    bad++;
                    $display("FAIL held_colour oe=%0b bus=%b want oe=1 bus=%b", colour_oe, colour_bus, col);
                end
            end
        end
        btn_in = 4'd0;
    endtask

    task automatic check_deltas(input string name, input int c0, input int f0, input int ec, input int ef);
        total++;
        if ((n_comp - c0) !== ec || (n_fail - f0) !== ef) begin
            bad++;
            $display("FAIL %s complete=%0d fail=%0d want complete=%0d fail=%0d",
                     name, n_comp - c0, n_fail - f0, ec, ef);
        end
    endtask

    task automatic test_reset();
        rst_input_n  = 1'b0;
        en_input     = 1'b0;
        btn_in       = 4'd0;
        round_ctr    = 4'd0;
        seq_in_input = 32'd0;
        tick(3);
        total++;
        if ({colour_bus, colour_oe, complete_input, fail_input} !== 5'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=00000", {colour_bus, colour_oe, complete_input, fail_input});
        end
        rst_input_n = 1'b1;
        tick(2);
    endtask

    task automatic test_correct_round();
        int c0, f0;
        seq_in_input = $urandom;
        seq_in_input[5:0] = 6'b10_01_11;
        round_ctr = 4'd2;
        en_input = 1'b1;
        tick(2);
        c0 = n_comp; f0 = n_fail;
        press_hold(4'b1000, 10, 1'b1, 2'b11); tick(10);
        press_hold(4'b0010, 10, 1'b1, 2'b01); tick(10);
        press_hold(4'b0100, 10, 1'b1, 2'b10); tick(10);
        check_deltas("correct_round", c0, f0, 1, 0);
        en_input = 1'b0;
        tick(3);
    endtask

    task automatic test_wrong_colour();
        int c0, f0, k;
        seq_in_input = $urandom;
        seq_in_input[3:0] = 4'b00_01;
        round_ctr = 4'd1;
        en_input = 1'b1;
        tick(2);
        c0 = n_comp; f0 = n_fail;
        btn_in = 4'b0100;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (fail_input) begin k = i; break; end
        end
        total++;
        if (k !== 7 || colour_oe !== 1'b1 || colour_bus !== 2'b10) begin
            bad++;
            $display("FAIL wrong_colour_timing cycle=%0d oe=%0b bus=%b want cycle=7 oe=1 bus=10", k, colour_oe, colour_bus);
        end
        btn_in = 4'd0;
        tick(10);
        check_deltas("wrong_colour_pulses", c0, f0, 0, 1);
        en_input = 1'b0;
        tick(3);
    endtask

    task automatic test_bounce_multi();
        int c0, f0, k;
        logic [1:0] col1;
        col1 = 2'($urandom_range(0, 3));
        seq_in_input = $urandom;
        seq_in_input[3:0] = {col1, 2'b00};
        round_ctr = 4'd1;
        en_input = 1'b1;
        tick(2);
        c0 = n_comp; f0 = n_fail;
        for (int i = 0; i < 6; i++) begin
            btn_in = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            tick(2);
        end
        press_hold(4'b0001, 10, 1'b1, 2'b00); tick(10);
        check_deltas("bounce_single_press", c0, f0, 0, 0);
        press_hold(4'(1) << col1, 10, 1'b1, col1); tick(10);
        check_deltas("bounce_round_done", c0, f0, 1, 0);
        en_input = 1'b0;
        tick(3);

        en_input = 1'b1;
        tick(2);
        c0 = n_comp; f0 = n_fail;
        btn_in = 4'b0011;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (fail_input) begin k = i; break; end
        end
        total++;
        if (k !== 7 || colour_oe !== 1'b0) begin
            bad++;
            $display("FAIL multi_press cycle=%0d oe=%0b want cycle=7 oe=0", k, colour_oe);
        end
        btn_in = 4'd0;
        tick(10);
        check_deltas("multi_press_pulses", c0, f0, 0, 1);
        en_input = 1'b0;
        tick(3);
    endtask

    task automatic test_abort();
        int c0, f0;
        logic [1:0] col;
        col = 2'($urandom_range(0, 3));
        seq_in_input = $urandom;
        seq_in_input[1:0] = col;
        round_ctr = 4'd2;
        en_input = 1'b1;
        tick(2);
        c0 = n_comp; f0 = n_fail;
        btn_in = 4'(1) << col;
        tick(9);
        total++;
        if (colour_oe !== 1'b1) begin
            bad++;
            $display("FAIL abort_pre_oe got=%0b want=1", colour_oe);
        end
        en_input = 1'b0;
        tick(1);
        total++;
        if (colour_oe !== 1'b0) begin
            bad++;
            $display("FAIL abort_oe got=%0b want=0", colour_oe);
        end
        btn_in = 4'd0;
        tick(10);
        check_deltas("abort_pulses", c0, f0, 0, 0);
    endtask

    task automatic test_reset_midround();
        int c0, f0;
        seq_in_input = $urandom;
        seq_in_input[5:0] = 6'b01_10_11;
        round_ctr = 4'd2;
        en_input = 1'b1;
        tick(2);
        press_hold(4'b1000, 10, 1'b1, 2'b11); tick(10);
        btn_in = 4'b0100;
        tick(9);
        rst_input_n = 1'b0;
        tick(1);
        total++;
        if ({colour_bus, colour_oe, complete_input, fail_input} !== 5'd0) begin
            bad++;
            $display("FAIL midround_reset got=%b want=00000", {colour_bus, colour_oe, complete_input, fail_input});
        end
        tick(2);
        btn_in = 4'd0;
        rst_input_n = 1'b1;
        tick(10);
        c0 = n_comp; f0 = n_fail;
        press_hold(4'b1000, 10, 1'b1, 2'b11); tick(10);
        press_hold(4'b0100, 10, 1'b1, 2'b10); tick(10);
        press_hold(4'b0010, 10, 1'b1, 2'b01); tick(10);
        check_deltas("restart_after_reset", c0, f0, 1, 0);
        en_input = 1'b0;
        tick(3);
    endtask

    task automatic test_held_on_entry();
        int c0, f0;
        seq_in_input = $urandom;
        seq_in_input[1:0] = 2'b01;
        round_ctr = 4'd0;
        en_input = 1'b0;
        btn_in = 4'b0010;
        tick(10);
        c0 = n_comp; f0 = n_fail;
        en_input = 1'b1;
        tick(12);
        total++;
        if (colour_oe !== 1'b0 || (n_fail - f0) !== 0 || (n_comp - c0) !== 0) begin
            bad++;
            $display("FAIL held_on_entry oe=%0b pulses=%0d want oe=0 pulses=0", colour_oe, (n_fail - f0) + (n_comp - c0));
        end
        btn_in = 4'd0;
        tick(10);
        press_hold(4'b0010, 10, 1'b1, 2'b01); tick(10);
        check_deltas("held_on_entry_repress", c0, f0, 1, 0);
        en_input = 1'b0;
        tick(3);
    endtask

    task automatic test_timeout();
        int k;
        round_ctr = 4'd0;
        btn_in = 4'd0;
        en_input = 1'b0;
        tick(3);
        en_input = 1'b1;
        k = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (fail_input) begin k = i; break; end
        end
        total++;
`ifdef INPUT_TIMEOUT_EN
        if (k !== 65) begin
            bad++;
            $display("FAIL timeout_cycle got=%0d want=65", k);
        end
`else
        if (k !== 0) begin
            bad++;
            $display("FAIL no_timeout fail_at=%0d want=none", k);
        end
`endif
        en_input = 1'b0;
        tick(3);
    endtask

    // Reference: the round fails at the first press whose colour differs from the
    // sequence entry at that position, otherwise completes after round_ctr+1 presses.
    task automatic test_random_rounds();
        int c0, f0, exp_fail;
        logic [1:0] c, pc;
        logic wrong;
        for (int it = 0; it < 8; it++) begin
            seq_in_input = $urandom;
            round_ctr = 4'($urandom_range(0, 4));
            en_input = 1'b1;
            tick(2);
            c0 = n_comp; f0 = n_fail;
            exp_fail = 0;
            for (int i = 0; i <= int'(round_ctr); i++) begin
                c = seq_in_input[2*i +: 2];
                wrong = ($urandom_range(0, 4) == 0);
                pc = wrong ? (c ^ 2'($urandom_range(1, 3))) : c;
                press_hold(4'(1) << pc, $urandom_range(9, 14), !wrong, pc);
                tick($urandom_range(8, 14));
                if (wrong) begin
                    exp_fail = 1;
                    break;
                end
            end
            check_deltas("random_round", c0, f0, 1 - exp_fail, exp_fail);
            en_input = 1'b0;
            tick(3);
        end
    endtask

    task automatic test_pulse_hygiene();
        total++;
        if (n_overlap !== 0 || n_wide !== 0) begin
            bad++;
            $display("FAIL pulse_shape overlap=%0d wide=%0d want 0 0", n_overlap, n_wide);
        end
    endtask

    initial begin
        test_reset();
        test_correct_round();
        test_wrong_colour();
        test_bounce_multi();
        test_abort();
        test_reset_midround();
        test_held_on_entry();
        test_timeout();
        test_random_rounds();
        test_pulse_hygiene();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/input_state.md
Name: input_state

Overview:
- Player-side counterpart of the colour display stage: captures the player's button presses for one round and checks each press against the stored sequence.
- Synchronises and debounces four raw buttons, then decodes each valid press to a 2-bit colour and compares it to the expected colour.
- Echoes the pressed colour on the shared colour bus.
- Reports one of two results to the game controller: success (all round_ctr+1 colours correct) or failure.

Parameters:
- DEBOUNCE_CYCLES, 100_000, clk ticks the synchronised button vector must stay unchanged before it is accepted (10 ms at 10 MHz).
- TIMEOUT_CYCLES, 50_000_000, clk ticks allowed between presses when INPUT_TIMEOUT_EN is defined (5 s at 10 MHz).

Ports:
- clk  in  1  system clock
- rst_input_n  in  1  synchronous reset, active-low
- en_input  in  1  high = capture round; low = abort and idle
- seq_in_input  in  32  16 colours packed LSB-first, colour k at bits [2k+1:2k]
- round_ctr  in  4  N ⇒ expect N+1 presses
- btn_in  in  4  raw asynchronous buttons, active-high
- colour_bus  out  2  colour of the button currently held
- colour_oe  out  1  1 = colour_bus valid
- complete_input  out  1  1-cycle pulse: whole round entered correctly
- fail_input  out  1  1-cycle pulse: wrong colour, multi-press or timeout

Behaviour:
- Reset: all outputs 0, pos=0, state IDLE, debounced vector 0000, all counters 0. Reset mid-round aborts with no pulse.
- Synchroniser: 2-FF synchroniser on btn_in.
- Debounce:
  - The stable counter clears whenever the synchronised vector differs from the previous sample.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced vector takes the sample.
  - Latency from btn_in edge to debounced update = 2 + DEBOUNCE_CYCLES cycles.
- Counter widths: ceil(log2(param)), minimum 1 bit. All counters saturate-free and wrap only by explicit clear.
- Colour map: btn[0]→00, btn[1]→01, btn[2]→10, btn[3]→11.
- IDLE:
  - Ignores buttons.
  - en_input=1 → ARMED, pos=0.
- ARMED:
  - Press event = debounced vector goes 0000 → non-zero.
  - A button already held on entry is ignored until it is released.
  - Non-one-hot press → fail_input next cycle, go IDLE.
  - One-hot press whose colour ≠ seq_in_input[2*pos +: 2] → fail_input next cycle, go IDLE. colour_oe is asserted for that press too.
  - Matching press → WAIT_RELEASE.
- WAIT_RELEASE:
  - colour_oe=1 and colour_bus=pressed colour, registered one cycle after the press event.
  - When the debounced vector returns to 0000, colour_oe drops on the next cycle.
  - Release with pos==round_ctr → complete_input pulse, go IDLE.
  - Release otherwise → pos+1, go ARMED.
  - A change to a different non-zero vector while held is ignored until full release.
- en_input low in any state: go IDLE the next cycle, colour_oe=0, no pulse. This takes priority over a same-cycle press or release.
- complete_input and fail_input are never high together and are never high for more than 1 cycle.
- round_ctr and seq_in_input are sampled live and must stay constant while en_input=1.
- round_ctr=0: a single correct press-and-release completes the round.

Optional Feature:
- Macro INPUT_TIMEOUT_EN.
- Defined:
  - The timeout counter runs only in ARMED; it clears on entry to ARMED and on every accepted press.
  - On reaching TIMEOUT_CYCLES-1 → fail_input pulse, go IDLE.
- Undefined: no timeout counter; ARMED waits indefinitely. The TIMEOUT_CYCLES parameter remains but is unused.

Decomposition:
- Package simon_pkg holds:
  - colour code constants (RED=00, GREEN=01, BLUE=10, YELLOW=11);
  - the input_state state enum (IDLE, ARMED, WAIT_RELEASE);
  - the button-to-colour decode function.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES, 4-bit): synchroniser plus stable counter, output = debounced vector.
- input_state instantiates one btn_debounce and contains the FSM and comparison logic.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=64.
- Correct round: round_ctr=2, seq=…_10_01_11, presses btn[3], btn[1], btn[2], each held 10 cycles → colour_bus shows 11, 01, 10 while held; complete_input pulses once after the final release; fail_input stays 0.
- Wrong colour: round_ctr=1, seq=…_00_01, press btn[2] → fail_input pulses one cycle after the debounced press; state IDLE; no complete_input.
- Bounce and multi-press:
  - btn[0] toggling every 2 cycles for 12 cycles, then stable → exactly one press accepted.
  - btn[0] and btn[1] pressed together → fail_input.
- Abort and reset:
  - en_input dropped during WAIT_RELEASE → colour_oe=0 next cycle, no pulses.
  - rst_input_n=0 mid-round → all outputs 0; re-enable restarts from pos=0.
- Held-on-entry: btn[1] held before en_input rises → no press until release and re-press; then accepted as colour 01.
- Timeout (INPUT_TIMEOUT_EN): en_input=1, no presses → fail_input exactly 64 cycles after ARMED entry. Without the macro → no pulse after 200 cycles.
